// File: rtl/reaction_time_bcd_conv.sv
// Reaction-time converter: raw cycle count -> milliseconds -> four BCD digits.
// Sequential restoring divider (one quotient bit per cycle), clamp to 9999,
// then shift-add-3 binary-to-BCD. Results update only when a conversion finishes.
// Optional feature: define ROUND_EN to round to the nearest ms (.5 rounds up).
module reaction_time_bcd_conv #(
  parameter int unsigned BIN_W      = 28,
  parameter int unsigned CYC_PER_MS = 50000,
  parameter int unsigned Q_W        = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             ready,
  output logic             done_tick,
  output logic             overflow,
  output logic [3:0]       bcd3,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd0
);

`ifdef ROUND_EN
  localparam int unsigned DVD_W = BIN_W + 1;
`else
  localparam int unsigned DVD_W = BIN_W;
`endif
  localparam int unsigned REM_W  = BIN_W + 1;
  localparam int unsigned CNT_W  = $clog2(((DVD_W > Q_W) ? DVD_W : Q_W) + 1);
  localparam int unsigned MAX_MS = 9999;

  typedef enum logic [1:0] {IDLE, DIV, BCD, DONE} state_e;

  state_e             state_q, state_d;
  logic [DVD_W-1:0]   dvd_q, dvd_d;        // dividend shifting out, quotient shifting in
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [Q_W-1:0]     val_q, val_d;        // clamped ms value feeding the BCD loop
  logic [15:0]        dig_q, dig_d;        // BCD working digits
  logic               ovf_pend_q, ovf_pend_d;
  logic [15:0]        bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;

  logic [REM_W-1:0]   rem_sh;
  logic               rem_ge;
  logic [15:0]        dig_adj;

  // Next-state and datapath for divider, clamp, BCD loop and result capture
  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    val_d      = val_q;
    dig_d      = dig_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    ready_d    = 1'b0;
    rem_sh     = REM_W'({rem_q, dvd_q[DVD_W-1]});
    rem_ge     = (rem_sh >= REM_W'(CYC_PER_MS));
    dig_adj    = dig_q;
    for (int i = 0; i < 4; i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef ROUND_EN
          dvd_d = DVD_W'(bin) + DVD_W'(CYC_PER_MS / 2);
`else
          dvd_d = DVD_W'(bin);
`endif
          rem_d   = '0;
          cnt_d   = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        if (cnt_q == CNT_W'(DVD_W)) begin
          // Quotient complete: clamp and hand over to the BCD loop
          ovf_pend_d = (dvd_q > DVD_W'(MAX_MS));
          val_d      = ovf_pend_d ? Q_W'(MAX_MS) : dvd_q[Q_W-1:0];
          dig_d      = '0;
          cnt_d      = '0;
          state_d    = BCD;
        end else begin
          rem_d = rem_ge ? (rem_sh - REM_W'(CYC_PER_MS)) : rem_sh;
          dvd_d = {dvd_q[DVD_W-2:0], rem_ge};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BCD: begin
        {dig_d, val_d} = {dig_adj, val_q} << 1;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(Q_W - 1)) begin
          bcd_d   = {dig_adj[14:0], val_q[Q_W-1]};
          ovf_d   = ovf_pend_q;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    done_d  = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  // State and datapath registers, asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      dvd_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      val_q      <= '0;
      dig_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      val_q      <= val_d;
      dig_q      <= dig_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign ready     = ready_q;
  assign done_tick = done_q;
  assign overflow  = ovf_q;
  assign bcd3      = bcd_q[15:12];
  assign bcd2      = bcd_q[11:8];
  assign bcd1      = bcd_q[7:4];
  assign bcd0      = bcd_q[3:0];

endmodule

// File: tb/tb_reaction_time_bcd_conv.sv
// Bench for reaction_time_bcd_conv: directed corner cases plus random counts
// against an arithmetic millisecond/decimal reference model.
module tb_reaction_time_bcd_conv;

`ifdef ROUND_EN
  localparam int LAT = 44;
  localparam bit RND = 1'b1;
`else
  localparam int LAT = 43;
  localparam bit RND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [27:0] bin_a = '0, bin_b = '0;
  logic        rdy_a, done_a, ovf_a, rdy_b, done_b, ovf_b;
  logic [3:0]  d3_a, d2_a, d1_a, d0_a, d3_b, d2_b, d1_b, d0_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  reaction_time_bcd_conv #(.BIN_W(28), .CYC_PER_MS(50000), .Q_W(14)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bin(bin_a), .ready(rdy_a),
    .done_tick(done_a), .overflow(ovf_a), .bcd3(d3_a), .bcd2(d2_a), .bcd1(d1_a), .bcd0(d0_a));

  reaction_time_bcd_conv #(.BIN_W(28), .CYC_PER_MS(1), .Q_W(14)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bin(bin_b), .ready(rdy_b),
    .done_tick(done_b), .overflow(ovf_b), .bcd3(d3_b), .bcd2(d2_b), .bcd1(d1_b), .bcd0(d0_b));

  function automatic logic get_rdy(input bit sel);
    return sel ? rdy_b : rdy_a;
  endfunction
  function automatic logic get_done(input bit sel);
    return sel ? done_b : done_a;
  endfunction
  function automatic logic get_ovf(input bit sel);
    return sel ? ovf_b : ovf_a;
  endfunction
  function automatic logic [15:0] get_bcd(input bit sel);
    return sel ? {d3_b, d2_b, d1_b, d0_b} : {d3_a, d2_a, d1_a, d0_a};
  endfunction

  // Reference: {overflow, thousands, hundreds, tens, units} of the ms value
  function automatic logic [16:0] model(input longint b, input longint c);
    longint ms;
    logic   ov;
    ms = (b + (RND ? c / 2 : 0)) / c;
    ov = (ms > 9999);
    if (ov) ms = 9999;
    return {ov, 4'(ms / 1000), 4'((ms / 100) % 10), 4'((ms / 10) % 10), 4'(ms % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit sel, input logic v, input logic [27:0] b);
    if (sel) begin start_b = v; bin_b = b; end
    else     begin start_a = v; bin_a = b; end
  endtask

  // One conversion; optionally pulses start again pulse_at cycles in with another bin
  task automatic run_conv(input string tag, input bit sel, input logic [27:0] b, input int pulse_at);
    logic [16:0] exp;
    int  n;
    bit  seen, rdy_hi;
    exp = model(longint'(b), sel ? 64'sd1 : 64'sd50000);
    @(negedge clk);
    set_start(sel, 1'b1, b);
    @(posedge clk); #1;
    set_start(sel, 1'b0, 28'($urandom));
    n = 0; seen = 1'b0; rdy_hi = 1'b0;
    while (!seen && n < LAT + 20) begin
      if (get_rdy(sel)) rdy_hi = 1'b1;
      if (pulse_at != 0 && n == pulse_at) set_start(sel, 1'b1, 28'($urandom));
      @(posedge clk); #1;
      set_start(sel, 1'b0, 28'($urandom));
      n++;
      if (get_done(sel)) seen = 1'b1;
    end
    check({tag, ".latency"}, 32'(n), 32'(LAT));
    check({tag, ".ready_low"}, 32'(rdy_hi), 32'd0);
    check({tag, ".bcd"}, 32'(get_bcd(sel)), 32'(exp[15:0]));
    check({tag, ".ovf"}, 32'(get_ovf(sel)), 32'(exp[16]));
    @(posedge clk); #1;
    check({tag, ".one_pulse"}, 32'(get_done(sel)), 32'd0);
    check({tag, ".ready_back"}, 32'(get_rdy(sel)), 32'd1);
  endtask

  task automatic expect_quiet(input string tag, input bit sel, input int cycles);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (get_done(sel)) hit = 1'b1;
    end
    check({tag, ".no_done"}, 32'(hit), 32'd0);
  endtask

  initial begin
    logic [27:0] r;
    repeat (3) @(posedge clk);
    #1;
    check("reset.ready", 32'(rdy_a), 32'd1);
    check("reset.done", 32'(done_a), 32'd0);
    check("reset.ovf", 32'(ovf_a), 32'd0);
    check("reset.bcd", 32'({d3_a, d2_a, d1_a, d0_a}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_conv("zero", 1'b0, 28'd0, 0);
    run_conv("mid", 1'b0, 28'd12_345_678, 0);
    run_conv("max", 1'b0, 28'hFFF_FFFF, 0);
    run_conv("div1_10000", 1'b1, 28'd10_000, 0);
    run_conv("div1_9999", 1'b1, 28'd9_999, 0);

    // Second start mid-conversion is dropped, not queued
    run_conv("ignored", 1'b0, 28'd1_000_000, 5);
    expect_quiet("ignored.noqueue", 1'b0, LAT + 5);

    // Asynchronous reset partway through a conversion
    @(negedge clk);
    set_start(1'b0, 1'b1, 28'd33_333_333);
    @(posedge clk); #1;
    set_start(1'b0, 1'b0, 28'd0);
    repeat (20) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort.ready", 32'(rdy_a), 32'd1);
    check("abort.done", 32'(done_a), 32'd0);
    check("abort.bcd", 32'({d3_a, d2_a, d1_a, d0_a}), 32'd0);
    check("abort.ovf", 32'(ovf_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    expect_quiet("abort", 1'b0, LAT + 5);
    run_conv("after_abort", 1'b0, 28'd7_654_321, 0);

    // Random counts over the full range and around the clamp boundary
    for (int i = 0; i < 12; i++) begin
      r = 28'($urandom);
      run_conv("rand_full", 1'b0, r, 0);
    end
    for (int i = 0; i < 8; i++) begin
      r = 28'($urandom_range(0, 600_000_000) & 32'h0FFF_FFFF);
      run_conv("rand_ms", 1'b0, r, 0);
    end
    for (int i = 0; i < 8; i++) begin
      r = 28'($urandom_range(9_000, 11_000));
      run_conv("rand_clamp", 1'b1, r, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
